ssd_bcd_driver: RTL and testbench

Seven-segment display back end for the single-cycle CPU board top. It consumes the 13-bit binary debug value the top level selects onto its SSD bus (`SSDSel` mux output) and converts it to four BCD digits with a sequential shift-add-3 (double-dabble) engine. It then time-multiplexes the digits onto a common 4-digit active-low display. The display register updates atomically only after a conversion completes, so a value that changes mid-conversion never produces a torn display.

---
 rtl/ssd_bcd_driver.sv | 141 ++++++++++++++
 tb/tb_ssd_bcd_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/ssd_bcd_driver.sv
// rtl/ssd_bcd_driver.sv - 13-bit binary to 4-digit BCD seven-segment driver
// Sequential double-dabble conversion feeding a time-multiplexed active-low display.
module ssd_bcd_driver #(
    parameter int REFRESH_CYCLES = 100000,
    parameter bit BLANK_LZ       = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [12:0] value,
    output logic [3:0]  anode,
    output logic [6:0]  cathode,
    output logic        busy,
    output logic [15:0] bcd
);

    localparam int RW = (REFRESH_CYCLES > 2) ? $clog2(REFRESH_CYCLES) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state, state_next;
    logic        load, commit;
    logic [12:0] shift_bin;
    logic [15:0] shift_bcd;
    logic [15:0] bcd_adj;
    logic [3:0]  shift_cnt;
    logic [12:0] last_value;
    logic        start_pending;

    logic [RW-1:0] refresh_cnt;
    logic          refresh_wrap;
    logic [1:0]    idx, idx_next;
    logic [3:0]    digit;
    logic          blank;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0010000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    always_comb begin
        state_next = state;
        load       = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (start_pending || (value != last_value)) begin
                    load       = 1'b1;
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                if (shift_cnt == 4'd12) state_next = DONE;
            end
            DONE: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Add-3 correction is applied before each shift so no nibble ever exceeds 9.
    always_comb begin
        bcd_adj = shift_bcd;
        for (int i = 0; i < 4; i++) begin
            if (shift_bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = shift_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            shift_bin     <= '0;
            shift_bcd     <= '0;
            shift_cnt     <= '0;
            last_value    <= '0;
            start_pending <= 1'b1;
            bcd           <= '0;
        end else if (load) begin
            shift_bin     <= value;
            last_value    <= value;
            shift_bcd     <= '0;
            shift_cnt     <= '0;
            start_pending <= 1'b0;
        end else if (state == SHIFT) begin
            {shift_bcd, shift_bin} <= {bcd_adj[14:0], shift_bin, 1'b0};
            shift_cnt              <= shift_cnt + 4'd1;
        end else if (commit) begin
            bcd <= shift_bcd;
        end
    end

    assign busy = (state != IDLE);

    assign refresh_wrap = (refresh_cnt == RW'(REFRESH_CYCLES - 1));
    assign idx_next     = refresh_wrap ? idx + 2'd1 : idx;

    always_comb begin
        digit = bcd[{idx_next, 2'b00} +: 4];
        blank = 1'b0;
        if (BLANK_LZ) begin
            case (idx_next)
                2'd1:    blank = (bcd[15:4] == 12'd0);
                2'd2:    blank = (bcd[15:8] == 8'd0);
                2'd3:    blank = (bcd[15:12] == 4'd0);
                default: blank = 1'b0;
            endcase
        end
    end

    // anode and cathode are both derived from idx_next so they switch on the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            refresh_cnt <= '0;
            idx         <= 2'd0;
            anode       <= 4'b1110;
            cathode     <= 7'b1000000;
        end else begin
            refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;
            idx         <= idx_next;
            anode       <= ~(4'b0001 << idx_next);
            cathode     <= blank ? 7'b1111111 : seg7(digit);
        end
    end

endmodule

// File: tb/tb_ssd_bcd_driver.sv
// tb/tb_ssd_bcd_driver.sv - scoreboard bench for ssd_bcd_driver
module tb_ssd_bcd_driver;

    logic        clk = 1'b0;
    logic        rst;
    logic [12:0] value;
    logic [3:0]  anode, anode_nb;
    logic [6:0]  cathode, cathode_nb;
    logic        busy, busy_nb;
    logic [15:0] bcd, bcd_nb;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q[$];
    int          run_len = 0;
    logic        prev_busy = 1'b0;

    ssd_bcd_driver #(.REFRESH_CYCLES(4), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode), .cathode(cathode), .busy(busy), .bcd(bcd)
    );

    ssd_bcd_driver #(.REFRESH_CYCLES(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .value(value),
        .anode(anode_nb), .cathode(cathode_nb), .busy(busy_nb), .bcd(bcd_nb)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic logic [6:0] exp_seg(input logic [15:0] b, input int d, input bit blank_lz);
        logic [15:0] upper;
        logic [3:0]  nib;
        upper = b >> (4 * d);
        nib   = upper[3:0];
        if (blank_lz && d >= 1 && upper == 16'd0) return 7'b1111111;
        case (nib)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // Scoreboard: every completed conversion pops one expected BCD word.
    always @(negedge clk) begin
        if (!rst) begin
            prev_busy = 1'b0;
            run_len   = 0;
        end else begin
            if (busy) run_len++;
            if (prev_busy && !busy) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_commit", {16'h0, bcd}, 32'hDEAD_BEEF);
                end else begin
                    check("bcd_commit", {16'h0, bcd}, {16'h0, exp_q.pop_front()});
                    check("busy_len", run_len, 14);
                end
                run_len = 0;
            end
            prev_busy = busy;
        end
    end

    task automatic wait_done();
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check("wait_done_queue", exp_q.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_scan(input logic [15:0] b);
        logic [3:0] prev_an;
        logic [3:0] exp_an;
        int         idx0;
        int         d;
        bit         found;
        found   = 1'b0;
        prev_an = anode;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (anode !== prev_an) begin
                found = 1'b1;
                break;
            end
            prev_an = anode;
        end
        check("scan_align", {31'd0, found}, 32'd1);
        idx0 = 0;
        for (int j = 0; j < 4; j++) if (anode[j] == 1'b0) idx0 = j;
        for (int k = 0; k < 16; k++) begin
            if (k > 0) @(negedge clk);
            d      = (idx0 + k / 4) % 4;
            exp_an = ~(4'b0001 << d);
            check("scan_anode", {28'd0, anode}, {28'd0, exp_an});
            check("scan_anode_nb", {28'd0, anode_nb}, {28'd0, exp_an});
            check("scan_cath_blank", {25'd0, cathode}, {25'd0, exp_seg(b, d, 1'b1)});
            check("scan_cath_noblank", {25'd0, cathode_nb}, {25'd0, exp_seg(b, d, 1'b0)});
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        int rises;
        logic pb;

        // 1: reset state and forced conversion of 0
        rst   = 1'b0;
        value = 13'd0;
        repeat (3) @(negedge clk);
        check("rst_anode", {28'd0, anode}, 32'b1110);
        check("rst_cathode", {25'd0, cathode}, 32'b1000000);
        check("rst_bcd", {16'd0, bcd}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        exp_q.push_back(to_bcd(0));
        rst = 1'b1;
        wait_done();
        check_scan(to_bcd(0));

        // 2: 1234
        value = 13'd1234;
        exp_q.push_back(to_bcd(1234));
        wait_done();
        check_scan(to_bcd(1234));

        // 3: max value, then small value for blanking in both modes
        value = 13'd8191;
        exp_q.push_back(to_bcd(8191));
        wait_done();
        check("nb_bcd_8191", {16'd0, bcd_nb}, {16'd0, to_bcd(8191)});
        value = 13'd7;
        exp_q.push_back(to_bcd(7));
        wait_done();
        check("nb_bcd_7", {16'd0, bcd_nb}, {16'd0, to_bcd(7)});
        check_scan(to_bcd(7));

        // 4: changes during SHIFT are deferred; 200 is never committed
        value = 13'd100;
        exp_q.push_back(to_bcd(100));
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        check("t4_busy_rise", {31'd0, busy}, 32'd1);
        repeat (2) @(negedge clk);
        value = 13'd200;
        repeat (6) @(negedge clk);
        value = 13'd300;
        exp_q.push_back(to_bcd(300));
        wait_done();

        // 5: reset mid-conversion aborts without committing
        value = 13'd4095;
        for (int i = 0; i < 10 && !busy; i++) @(negedge clk);
        check("t5_busy_rise", {31'd0, busy}, 32'd1);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort_bcd", {16'd0, bcd}, 32'd0);
        check("abort_anode", {28'd0, anode}, 32'b1110);
        check("abort_cathode", {25'd0, cathode}, 32'b1000000);
        check("abort_busy", {31'd0, busy}, 32'd0);
        repeat (2) @(negedge clk);
        exp_q.push_back(to_bcd(4095));
        rst = 1'b1;
        wait_done();
        check_scan(to_bcd(4095));

        // 6: constant value for 1000 cycles converts exactly once
        value = 13'd42;
        exp_q.push_back(to_bcd(42));
        rises = 0;
        pb    = busy;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (busy && !pb) rises++;
            pb = busy;
        end
        check("t6_conversions", rises, 1);
        check("t6_queue", exp_q.size(), 0);
        check_scan(to_bcd(42));

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
